nth_one_detector: RTL and testbench

- Multi-channel, parametrised successor of the team's single-input Moore "every third 1" detector.
- Each channel counts 1-samples on its input `x[i]` and raises `z[i]` for exactly one cycle after the Nth counted 1.
- N and the counting mode (cumulative or consecutive) are runtime-programmable and shared by all channels.
- Sits between synchronised event inputs and the interrupt/strobe logic in the SoC fabric.

---
 rtl/nth_one_pkg.sv | 13 +
 rtl/nth_one_channel.sv | 64 ++++++
 rtl/nth_one_detector.sv | 52 +++++
 tb/tb_nth_one_detector.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/nth_one_pkg.sv
// Shared types and constants for the N-th one detector channels.
package nth_one_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HIT
  } nth_state_t;

  localparam logic MODE_CUMUL  = 1'b0;
  localparam logic MODE_CONSEC = 1'b1;

endpackage

// File: rtl/nth_one_channel.sv
// One detector channel: counts 1-samples and flags the N-th one from state.
module nth_one_channel
  import nth_one_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             x,
  input  logic             clear_all,
  input  logic [CNT_W-1:0] n,
  input  logic             mode,
  output logic             z,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  nth_state_t       state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = count + ONE;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      count <= '0;
    end else if (clear_all || n == '0) begin
      state <= IDLE;
      count <= '0;
    end else begin
      unique case (state)
        IDLE, HIT: begin
          // A 1 in HIT starts a fresh run; with N=1 it lands straight in HIT again.
          if (x) begin
            state <= (n == ONE) ? HIT : COUNT;
            count <= ONE;
          end else begin
            state <= IDLE;
            count <= '0;
          end
        end
        COUNT: begin
          if (x) begin
            state <= (count_inc == n) ? HIT : COUNT;
            count <= count_inc;
          end else if (mode == MODE_CONSEC) begin
            state <= IDLE;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign z   = (state == HIT);
  assign cnt = count;

endmodule

// File: rtl/nth_one_detector.sv
// Multi-channel N-th one detector with shared runtime N and counting mode.
module nth_one_detector
  import nth_one_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned N_DEFAULT = 3
) (
  input  logic                      clock,
  input  logic                      n_reset,
  input  logic [CHANNELS-1:0]       x,
  input  logic                      clear,
  input  logic                      cfg_we,
  input  logic [CNT_W-1:0]          cfg_n,
  input  logic                      cfg_mode,
  output logic [CHANNELS-1:0]       z,
  output logic [CHANNELS*CNT_W-1:0] cnt,
  output logic [CNT_W-1:0]          n_cur,
  output logic                      mode_cur
);

  logic clear_all;

  // A config write also flushes every channel so no run straddles two configs.
  assign clear_all = clear | cfg_we;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      n_cur    <= CNT_W'(N_DEFAULT);
      mode_cur <= MODE_CUMUL;
    end else if (cfg_we) begin
      n_cur    <= cfg_n;
      mode_cur <= cfg_mode;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    nth_one_channel #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clock    (clock),
      .n_reset  (n_reset),
      .x        (x[i]),
      .clear_all(clear_all),
      .n        (n_cur),
      .mode     (mode_cur),
      .z        (z[i]),
      .cnt      (cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_nth_one_detector.sv
// Directed vector bench for nth_one_detector with hand-computed expectations.
module tb_nth_one_detector;

  logic        clock;
  logic        n_reset;
  logic [3:0]  x;
  logic        clear;
  logic        cfg_we;
  logic [3:0]  cfg_n;
  logic        cfg_mode;
  logic [3:0]  z;
  logic [15:0] cnt;
  logic [3:0]  n_cur;
  logic        mode_cur;

  int unsigned total;
  int unsigned bad;

  typedef struct packed {
    logic [3:0]  x;
    logic        clear;
    logic        cfg_we;
    logic [3:0]  cfg_n;
    logic        cfg_mode;
    logic [3:0]  exp_z;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_n;
    logic        exp_mode;
  } vec_t;

  vec_t vecs[$];

  nth_one_detector #(
    .CHANNELS (4),
    .CNT_W    (4),
    .N_DEFAULT(3)
  ) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .x       (x),
    .clear   (clear),
    .cfg_we  (cfg_we),
    .cfg_n   (cfg_n),
    .cfg_mode(cfg_mode),
    .z       (z),
    .cnt     (cnt),
    .n_cur   (n_cur),
    .mode_cur(mode_cur)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] vx, input logic vclr, input logic vwe,
                     input logic [3:0] vn, input logic vm, input logic [3:0] ez,
                     input logic [15:0] ec, input logic [3:0] en, input logic em);
    vec_t v;
    v.x = vx; v.clear = vclr; v.cfg_we = vwe; v.cfg_n = vn; v.cfg_mode = vm;
    v.exp_z = ez; v.exp_cnt = ec; v.exp_n = en; v.exp_mode = em;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [3:0] vx, input logic vclr, input logic vwe,
                      input logic [3:0] vn, input logic vm);
    x = vx; clear = vclr; cfg_we = vwe; cfg_n = vn; cfg_mode = vm;
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_reset = 1'b0;
    x = '0; clear = 1'b0; cfg_we = 1'b0; cfg_n = '0; cfg_mode = 1'b0;

    // Reset defaults: N=3 cumulative, ch0 x = 1,0,1,0,0,1,1
    add(4'b0001, 0, 0, 0, 0, 4'b0000, 16'h0001, 3, 0);
    add(4'b0000, 0, 0, 0, 0, 4'b0000, 16'h0001, 3, 0);
    add(4'b0001, 0, 0, 0, 0, 4'b0000, 16'h0002, 3, 0);
    add(4'b0000, 0, 0, 0, 0, 4'b0000, 16'h0002, 3, 0);
    add(4'b0000, 0, 0, 0, 0, 4'b0000, 16'h0002, 3, 0);
    add(4'b0001, 0, 0, 0, 0, 4'b0001, 16'h0003, 3, 0);
    add(4'b0001, 0, 0, 0, 0, 4'b0000, 16'h0001, 3, 0);
    // Program N=3 consecutive; x sampled with cfg_we is discarded
    add(4'b0011, 0, 1, 3, 1, 4'b0000, 16'h0000, 3, 1);
    // ch1 x = 1,1,0,1,1,1
    add(4'b0010, 0, 0, 0, 0, 4'b0000, 16'h0010, 3, 1);
    add(4'b0010, 0, 0, 0, 0, 4'b0000, 16'h0020, 3, 1);
    add(4'b0000, 0, 0, 0, 0, 4'b0000, 16'h0000, 3, 1);
    add(4'b0010, 0, 0, 0, 0, 4'b0000, 16'h0010, 3, 1);
    add(4'b0010, 0, 0, 0, 0, 4'b0000, 16'h0020, 3, 1);
    add(4'b0010, 0, 0, 0, 0, 4'b0010, 16'h0030, 3, 1);
    // N=1 cumulative: ch2 held high 4 cycles
    add(4'b0000, 0, 1, 1, 0, 4'b0000, 16'h0000, 1, 0);
    add(4'b0100, 0, 0, 0, 0, 4'b0100, 16'h0100, 1, 0);
    add(4'b0100, 0, 0, 0, 0, 4'b0100, 16'h0100, 1, 0);
    add(4'b0100, 0, 0, 0, 0, 4'b0100, 16'h0100, 1, 0);
    add(4'b0100, 0, 0, 0, 0, 4'b0100, 16'h0100, 1, 0);
    add(4'b0000, 0, 0, 0, 0, 4'b0000, 16'h0000, 1, 0);
    // N=0 disables every channel
    add(4'b0000, 0, 1, 0, 0, 4'b0000, 16'h0000, 0, 0);
    add(4'b0100, 0, 0, 0, 0, 4'b0000, 16'h0000, 0, 0);
    add(4'b0100, 0, 0, 0, 0, 4'b0000, 16'h0000, 0, 0);
    add(4'b0100, 0, 0, 0, 0, 4'b0000, 16'h0000, 0, 0);
    add(4'b0100, 0, 0, 0, 0, 4'b0000, 16'h0000, 0, 0);
    // N=2: clear collides with a 1 on ch3
    add(4'b0000, 0, 1, 2, 0, 4'b0000, 16'h0000, 2, 0);
    add(4'b1000, 0, 0, 0, 0, 4'b0000, 16'h1000, 2, 0);
    add(4'b1000, 1, 0, 0, 0, 4'b0000, 16'h0000, 2, 0);
    add(4'b1000, 0, 0, 0, 0, 4'b0000, 16'h1000, 2, 0);
    add(4'b1000, 0, 0, 0, 0, 4'b1000, 16'h2000, 2, 0);
    add(4'b0000, 0, 0, 0, 0, 4'b0000, 16'h0000, 2, 0);
    // Parallel identical runs, then staggered runs
    add(4'b1111, 0, 0, 0, 0, 4'b0000, 16'h1111, 2, 0);
    add(4'b1111, 0, 0, 0, 0, 4'b1111, 16'h2222, 2, 0);
    add(4'b0000, 0, 0, 0, 0, 4'b0000, 16'h0000, 2, 0);
    add(4'b0001, 0, 0, 0, 0, 4'b0000, 16'h0001, 2, 0);
    add(4'b0011, 0, 0, 0, 0, 4'b0001, 16'h0012, 2, 0);
    add(4'b0110, 0, 0, 0, 0, 4'b0010, 16'h0120, 2, 0);
    add(4'b1100, 0, 0, 0, 0, 4'b0100, 16'h1200, 2, 0);
    add(4'b1000, 0, 0, 0, 0, 4'b1000, 16'h2000, 2, 0);
    add(4'b0000, 0, 0, 0, 0, 4'b0000, 16'h0000, 2, 0);
    // clear and cfg_we together: config loads, channels cleared
    add(4'b0001, 0, 0, 0, 0, 4'b0000, 16'h0001, 2, 0);
    add(4'b0001, 1, 1, 5, 1, 4'b0000, 16'h0000, 5, 1);

    #7;
    check("reset_z", 32'(z), 32'h0);
    check("reset_cnt", 32'(cnt), 32'h0);
    check("reset_n", 32'(n_cur), 32'd3);
    check("reset_mode", 32'(mode_cur), 32'd0);

    @(negedge clock);
    n_reset = 1'b1;
    @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].x, vecs[i].clear, vecs[i].cfg_we, vecs[i].cfg_n, vecs[i].cfg_mode);
      check($sformatf("v%0d_z", i), 32'(z), 32'(vecs[i].exp_z));
      check($sformatf("v%0d_cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_n", i), 32'(n_cur), 32'(vecs[i].exp_n));
      check($sformatf("v%0d_mode", i), 32'(mode_cur), 32'(vecs[i].exp_mode));
    end

    // Async reset while ch0 sits in HIT under a non-default config
    step(4'b0000, 0, 1, 2, 1);
    step(4'b0001, 0, 0, 0, 0);
    step(4'b0001, 0, 0, 0, 0);
    check("pre_reset_z", 32'(z), 32'h1);
    check("pre_reset_cnt", 32'(cnt), 32'h2);
    #2;
    n_reset = 1'b0;
    #1;
    check("async_z", 32'(z), 32'h0);
    check("async_cnt", 32'(cnt), 32'h0);
    check("async_n", 32'(n_cur), 32'd3);
    check("async_mode", 32'(mode_cur), 32'd0);

    // Run resumes from defaults after release
    x = 4'b0001;
    @(negedge clock);
    n_reset = 1'b1;
    step(4'b0001, 0, 0, 0, 0);
    step(4'b0001, 0, 0, 0, 0);
    check("resume_z_n2", 32'(z), 32'h0);
    step(4'b0001, 0, 0, 0, 0);
    check("resume_z", 32'(z), 32'h1);
    check("resume_cnt", 32'(cnt), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
